dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl_if.sv | 44 ++++
 rtl/dcache_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side bus of the direct-mapped write-through data cache.
// Latency: n/a (wiring only); the slave modport is the cache, master is its environment.
// Backpressure: cpu_stall holds the CPU; mem_ready completes a memory transfer.
interface dcache_ctrl_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    // CPU side
    logic                     cpu_req;
    logic                     cpu_we;
    logic                     ByteOp;
    logic [ADDRESS_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0]    WriteData;
    logic                     flush;
    logic [DATA_WIDTH-1:0]    ReadData;
    logic                     cpu_stall;
    // memory side
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [3:0]               mem_be;
    logic                     mem_ready;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    // performance counters
    logic [31:0]              hit_count;
    logic [31:0]              miss_count;

    modport slave (
        input  cpu_req, cpu_we, ByteOp, Address, WriteData, flush,
        input  mem_ready, mem_rdata,
        output ReadData, cpu_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output hit_count, miss_count
    );

    modport master (
        output cpu_req, cpu_we, ByteOp, Address, WriteData, flush,
        output mem_ready, mem_rdata,
        input  ReadData, cpu_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-line, write-through/no-write-allocate data cache controller.
// Latency: load hit 0 cycles (combinational); miss/store = memory wait cycles + 2.
// Backpressure: cpu_stall high while a request is pending; memory side waits on mem_ready.
// Ports: clk, rst (async active-low), bus (dcache_ctrl_if.slave: CPU request/response,
//        memory request/response, hit/miss counters).
module dcache_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SET_WIDTH     = 6
) (
    input  logic          clk,
    input  logic          rst,
    dcache_ctrl_if.slave  bus
);
    localparam int TAG_WIDTH = ADDRESS_WIDTH - SET_WIDTH - 2;
    localparam int NUM_SETS  = 1 << SET_WIDTH;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} state_t;

    state_t state, state_nxt;

    logic [NUM_SETS-1:0]   valid;
    logic [TAG_WIDTH-1:0]  tag_mem  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_mem [NUM_SETS];

    // Request captured on acceptance so the memory bus stays stable during the wait.
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     req_byte;
    logic                     req_hit;
    logic [DATA_WIDTH-1:0]    resp_data;
    logic [31:0]              hit_q, miss_q;

    logic [SET_WIDTH-1:0] cur_idx, req_idx;
    logic [TAG_WIDTH-1:0] cur_tag, req_tag;
    logic                 lookup_hit;

    logic                  stall, hit_inc, miss_inc, flush_now, accept, fill_en, upd_en;
    logic [DATA_WIDTH-1:0] rdata;

    assign cur_idx    = bus.Address[SET_WIDTH+1:2];
    assign cur_tag    = bus.Address[ADDRESS_WIDTH-1:SET_WIDTH+2];
    assign req_idx    = req_addr[SET_WIDTH+1:2];
    assign req_tag    = req_addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
    assign lookup_hit = valid[cur_idx] && (tag_mem[cur_idx] == cur_tag);

    // Big-endian lanes: byte offset 0 is bits [31:24], offset 3 is bits [7:0].
    function automatic logic [DATA_WIDTH-1:0] load_fmt(input logic [DATA_WIDTH-1:0] word,
                                                       input logic byte_op,
                                                       input logic [1:0] off);
        int sh;
        sh = 8 * (3 - int'(off));
        if (byte_op) load_fmt = {{(DATA_WIDTH-8){1'b0}}, word[sh +: 8]};
        else         load_fmt = word;
    endfunction

    function automatic logic [3:0] lane_be(input logic byte_op, input logic [1:0] off);
        lane_be = byte_op ? (4'b1000 >> off) : 4'hF;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_word,
                                                    input logic [DATA_WIDTH-1:0] new_word,
                                                    input logic [3:0] be);
        merge = old_word;
        for (int i = 0; i < 4; i++)
            if (be[i]) merge[8*i +: 8] = new_word[8*i +: 8];
    endfunction

    logic [DATA_WIDTH-1:0] store_word;
    assign store_word = req_byte ? {(DATA_WIDTH/8){req_wdata[7:0]}} : req_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        stall         = 1'b0;
        rdata         = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = 4'h0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        flush_now     = 1'b0;
        accept        = 1'b0;
        fill_en       = 1'b0;
        upd_en        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flush) begin
                    // flush wins over a simultaneous request, which simply waits a cycle
                    flush_now = 1'b1;
                    stall     = bus.cpu_req;
                end else if (bus.cpu_req) begin
                    if (!bus.cpu_we && lookup_hit) begin
                        rdata   = load_fmt(data_mem[cur_idx], bus.ByteOp, bus.Address[1:0]);
                        hit_inc = 1'b1;
                    end else begin
                        stall  = 1'b1;
                        accept = 1'b1;
                        // stores are classified by lookup even though they always go to memory
                        if (bus.cpu_we && lookup_hit) hit_inc  = 1'b1;
                        else                          miss_inc = 1'b1;
                        state_nxt = bus.cpu_we ? WR_THRU : RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                stall        = bus.cpu_req;
                bus.mem_req  = 1'b1;
                bus.mem_be   = 4'hF;
                bus.mem_addr = {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
                if (bus.mem_ready) begin
                    fill_en   = 1'b1;
                    state_nxt = RESP;
                end
            end
            WR_THRU: begin
                stall         = bus.cpu_req;
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
                bus.mem_wdata = store_word;
                bus.mem_be    = lane_be(req_byte, req_addr[1:0]);
                if (bus.mem_ready) begin
                    upd_en    = req_hit;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rdata     = resp_data;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid     <= '0;
            hit_q     <= '0;
            miss_q    <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_byte  <= 1'b0;
            req_hit   <= 1'b0;
            resp_data <= '0;
        end else begin
            if (flush_now) valid <= '0;
            if (fill_en)   valid[req_idx] <= 1'b1;
            if (hit_inc)   hit_q  <= hit_q + 32'd1;
            if (miss_inc)  miss_q <= miss_q + 32'd1;
            if (accept) begin
                req_addr  <= bus.Address;
                req_wdata <= bus.WriteData;
                req_byte  <= bus.ByteOp;
                req_hit   <= lookup_hit;
            end
            if (fill_en) resp_data <= load_fmt(bus.mem_rdata, req_byte, req_addr[1:0]);
            else if (state == WR_THRU && bus.mem_ready) resp_data <= '0;
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= bus.mem_rdata;
        end
        if (upd_en)
            data_mem[req_idx] <= merge(data_mem[req_idx], store_word,
                                       lane_be(req_byte, req_addr[1:0]));
    end

    assign bus.ReadData   = rdata;
    assign bus.cpu_stall  = stall;
    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
endmodule
